// File: rtl/reservation_station_pkg.sv
// Shared types for the reservation station: operand/entry structs, station and opcode enums,
// and the CDB wakeup helpers used on both stored entries and same-cycle issue bypass.
package reservation_station_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int TAG_W_DEF = 6;

    typedef enum logic [1:0] {
        ST_ALU    = 2'd0,
        ST_LSU    = 2'd1,
        ST_BRANCH = 2'd2,
        ST_MULDIV = 2'd3
    } st_type_e;

    typedef enum logic [3:0] {
        OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
        OP_SLL, OP_SRL, OP_LW, OP_SW, OP_BEQ, OP_MUL
    } instr_name_e;

    typedef struct packed {
        logic [TAG_W_DEF-1:0] tag;
        logic [XLEN_DEF-1:0]  value;
        logic                 rdy;
    } src_opnd_t;

    typedef struct packed {
        logic [XLEN_DEF-1:0]  addr;
        logic [XLEN_DEF-1:0]  imm;
        instr_name_e          instr_name;
        logic [TAG_W_DEF-1:0] dest_tag;
        src_opnd_t            src1;
        src_opnd_t            src2;
    } rs_entry_t;

    // Port 1 is applied last so it wins a (never legal) double match.
    function automatic src_opnd_t wake_src(
        input src_opnd_t            s,
        input logic [1:0]           cv,
        input logic [TAG_W_DEF-1:0] t0,
        input logic [TAG_W_DEF-1:0] t1,
        input logic [XLEN_DEF-1:0]  d0,
        input logic [XLEN_DEF-1:0]  d1
    );
        src_opnd_t r;
        r = s;
        if (!s.rdy) begin
            if (cv[0] && t0 == s.tag) begin
                r.value = d0;
                r.rdy   = 1'b1;
            end
            if (cv[1] && t1 == s.tag) begin
                r.value = d1;
                r.rdy   = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic rs_entry_t wake_entry(
        input rs_entry_t            e,
        input logic [1:0]           cv,
        input logic [TAG_W_DEF-1:0] t0,
        input logic [TAG_W_DEF-1:0] t1,
        input logic [XLEN_DEF-1:0]  d0,
        input logic [XLEN_DEF-1:0]  d1
    );
        rs_entry_t r;
        r      = e;
        r.src1 = wake_src(e.src1, cv, t0, t1, d0, d1);
        r.src2 = wake_src(e.src2, cv, t0, t1, d0, d1);
        return r;
    endfunction

endpackage

// File: rtl/global_signals_if.sv
// Clock and synchronous reset bundle shared by pipeline blocks.
interface global_signals_if;
    logic clk;
    logic reset;
    modport dut (input clk, input reset);
endinterface

// File: rtl/reservation_station_rs_select.sv
// Priority encoder: lowest-index asserted request wins (index 0 is the oldest entry).
module rs_select #(
    parameter  int N  = 8,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    output logic [IW-1:0] idx_o,
    output logic          vld_o
);

    always_comb begin
        idx_o = '0;
        vld_o = |req_i;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Collapsing-queue reservation station: two-wide issue, CDB wakeup/bypass, oldest-ready dispatch.
// Optional sticky overflow detection is enabled by defining RS_OVERFLOW_CHK_EN.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int SIZE    = 8,
    parameter int ST_TYPE = 0,
    parameter int TAG_W   = TAG_W_DEF
) (
    global_signals_if.dut   gsi,
    input  logic             flush,
    input  logic [1:0]       issue_valid,
    input  logic [1:0]       issue_st_type [2],
    input  rs_entry_t        issue_entry   [2],
    input  logic [1:0]       cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag       [2],
    input  logic [XLEN-1:0]  cdb_data      [2],
    output logic             full,
    output logic             disp_valid,
    output rs_entry_t        disp_entry,
    input  logic             disp_ready,
    output logic             overflow_err
);

    localparam int CW = $clog2(SIZE + 1);
    localparam int IW = $clog2(SIZE);
    localparam logic [1:0] ST_SEL = 2'(ST_TYPE);

    rs_entry_t         entries_q [SIZE];
    rs_entry_t         entries_d [SIZE];
    rs_entry_t         woke      [SIZE];
    rs_entry_t         shifted   [SIZE];
    rs_entry_t         incoming  [2];
    rs_entry_t         first_in;
    logic [SIZE-1:0]   valid_q;
    logic [SIZE-1:0]   valid_d;
    logic [SIZE-1:0]   ready_vec;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic [CW-1:0]     cnt_rm;
    logic [CW-1:0]     free_slots;
    logic [CW-1:0]     n_acc;
    logic [CW-1:0]     n_keep;
    logic [1:0]        acc;
    logic [IW-1:0]     sel_idx;
    logic              sel_vld;
    logic              remove;

    // Selection looks only at registered state, so a wakeup becomes visible one cycle later.
    rs_select #(.N(SIZE)) u_select (
        .req_i (ready_vec),
        .idx_o (sel_idx),
        .vld_o (sel_vld)
    );

    assign disp_valid = sel_vld;
    assign disp_entry = sel_vld ? entries_q[sel_idx] : '0;
    assign remove     = sel_vld && disp_ready;
    assign full       = count_q >= CW'(SIZE - 1);

    for (genvar gi = 0; gi < 2; gi++) begin : g_issue
        assign acc[gi]      = !flush && issue_valid[gi] && (issue_st_type[gi] == ST_SEL);
        assign incoming[gi] = wake_entry(issue_entry[gi], cdb_valid, cdb_tag[0], cdb_tag[1],
                                         cdb_data[0], cdb_data[1]);
    end

    for (genvar gi = 0; gi < SIZE; gi++) begin : g_entry
        assign ready_vec[gi] = valid_q[gi] && entries_q[gi].src1.rdy && entries_q[gi].src2.rdy;
        assign woke[gi]      = wake_entry(entries_q[gi], cdb_valid, cdb_tag[0], cdb_tag[1],
                                          cdb_data[0], cdb_data[1]);
        if (gi < SIZE - 1) begin : g_shift
            assign shifted[gi] = (remove && IW'(gi) >= sel_idx) ? woke[gi+1] : woke[gi];
        end else begin : g_last
            assign shifted[gi] = woke[gi];
        end
        // Appends land right after the post-removal tail, older slot first.
        assign entries_d[gi] = (CW'(gi) == cnt_rm && n_keep != '0) ? first_in :
                               (CW'(gi) == cnt_rm + CW'(1) && n_keep == CW'(2)) ? incoming[1] :
                               shifted[gi];
        assign valid_d[gi]   = CW'(gi) < count_d;
    end

    always_comb begin
        cnt_rm     = count_q - CW'(remove);
        free_slots = CW'(SIZE) - cnt_rm;
        n_acc      = CW'(acc[0]) + CW'(acc[1]);
        n_keep     = (n_acc <= free_slots) ? n_acc : free_slots;
        first_in   = acc[0] ? incoming[0] : incoming[1];
        count_d    = cnt_rm + n_keep;
    end

    always_ff @(posedge gsi.clk) begin
        if (gsi.reset) begin
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < SIZE; i++) begin
                entries_q[i] <= '0;
            end
        end else if (flush) begin
            count_q <= '0;
            valid_q <= '0;
        end else begin
            count_q <= count_d;
            valid_q <= valid_d;
            for (int i = 0; i < SIZE; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

`ifdef RS_OVERFLOW_CHK_EN
    logic drop;
    logic overflow_q;

    // acc already excludes flush cycles, so a drop here is a genuine lost instruction.
    assign drop = n_acc > free_slots;

    always_ff @(posedge gsi.clk) begin
        if (gsi.reset) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
`ifndef SYNTHESIS
            $error("reservation_station: issue accepted with no free entry, instruction dropped");
`endif
        end
    end

    assign overflow_err = overflow_q;
`else
    assign overflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: issue, wakeup, bypass, ordering, fill/overflow, flush.
module tb_reservation_station;
    import reservation_station_pkg::*;

`ifdef RS_OVERFLOW_CHK_EN
    localparam logic EXP_OVF = 1'b1;
`else
    localparam logic EXP_OVF = 1'b0;
`endif

    global_signals_if gsi ();

    logic        flush;
    logic [1:0]  issue_valid;
    logic [1:0]  issue_st_type [2];
    rs_entry_t   issue_entry   [2];
    logic [1:0]  cdb_valid;
    logic [5:0]  cdb_tag       [2];
    logic [31:0] cdb_data      [2];
    logic        full;
    logic        disp_valid;
    rs_entry_t   disp_entry;
    logic        disp_ready;
    logic        overflow_err;

    int total = 0;
    int bad   = 0;

    reservation_station #(.XLEN(32), .SIZE(8), .ST_TYPE(0), .TAG_W(6)) dut (
        .gsi           (gsi),
        .flush         (flush),
        .issue_valid   (issue_valid),
        .issue_st_type (issue_st_type),
        .issue_entry   (issue_entry),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .cdb_data      (cdb_data),
        .full          (full),
        .disp_valid    (disp_valid),
        .disp_entry    (disp_entry),
        .disp_ready    (disp_ready),
        .overflow_err  (overflow_err)
    );

    initial gsi.clk = 1'b0;
    always #5 gsi.clk = ~gsi.clk;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        chk(tag, {159'b0, obs}, {159'b0, exp});
    endtask

    task automatic chk_ent(input string tag, input rs_entry_t obs, input rs_entry_t exp);
        chk(tag, {8'b0, obs}, {8'b0, exp});
    endtask

    task automatic chk_addr(input string tag, input logic [31:0] exp);
        chk(tag, {128'b0, disp_entry.addr}, {128'b0, exp});
    endtask

    task automatic tick();
        @(posedge gsi.clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush       = 1'b0;
        issue_valid = 2'b00;
        cdb_valid   = 2'b00;
    endtask

    function automatic rs_entry_t mk(input logic [31:0] a, input logic [5:0] t1, input logic r1,
                                     input logic [5:0] t2, input logic r2);
        rs_entry_t e;
        e            = '0;
        e.addr       = a;
        e.imm        = a ^ 32'h0000_5A5A;
        e.instr_name = OP_ADD;
        e.dest_tag   = a[7:2];
        e.src1.tag   = t1;
        e.src1.rdy   = r1;
        e.src1.value = r1 ? a + 32'd1 : 32'd0;
        e.src2.tag   = t2;
        e.src2.rdy   = r2;
        e.src2.value = r2 ? a + 32'd2 : 32'd0;
        return e;
    endfunction

    function automatic rs_entry_t fk(input int k);
        logic [5:0] t;
        t = (k == 0) ? 6'd21 : (k == 1) ? 6'd22 : 6'd20;
        return mk(32'h400 + 32'(4 * k), t, 1'b0, 6'd0, 1'b1);
    endfunction

    task automatic issue2(input rs_entry_t e0, input rs_entry_t e1);
        issue_valid      = 2'b11;
        issue_st_type[0] = 2'd0;
        issue_st_type[1] = 2'd0;
        issue_entry[0]   = e0;
        issue_entry[1]   = e1;
    endtask

    task automatic issue1(input rs_entry_t e0);
        issue_valid      = 2'b01;
        issue_st_type[0] = 2'd0;
        issue_entry[0]   = e0;
    endtask

    task automatic cdb(input int p, input logic [5:0] t, input logic [31:0] d);
        cdb_valid[p] = 1'b1;
        cdb_tag[p]   = t;
        cdb_data[p]  = d;
    endtask

    rs_entry_t   exp;
    rs_entry_t   ea;
    rs_entry_t   eb;
    logic [31:0] drain_addr [8];

    initial begin
        clear_inputs();
        disp_ready       = 1'b0;
        issue_st_type[0] = 2'd0;
        issue_st_type[1] = 2'd0;
        issue_entry[0]   = '0;
        issue_entry[1]   = '0;
        cdb_tag[0]       = '0;
        cdb_tag[1]       = '0;
        cdb_data[0]      = '0;
        cdb_data[1]      = '0;
        gsi.reset        = 1'b1;
        tick();
        tick();
        gsi.reset = 1'b0;

        // Reset state
        chk_bit("rst_full", full, 1'b0);
        chk_bit("rst_disp_valid", disp_valid, 1'b0);
        chk_ent("rst_disp_entry", disp_entry, '0);
        chk_bit("rst_overflow", overflow_err, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_bit("idle_full", full, 1'b0);
            chk_bit("idle_disp_valid", disp_valid, 1'b0);
        end

        // Two ready ADDs, dispatched back to back in age order
        disp_ready = 1'b1;
        issue2(mk(32'h100, 6'd0, 1'b1, 6'd0, 1'b1), mk(32'h104, 6'd0, 1'b1, 6'd0, 1'b1));
        tick();
        clear_inputs();
        chk_bit("add_n1_valid", disp_valid, 1'b1);
        chk_ent("add_n1_entry", disp_entry, mk(32'h100, 6'd0, 1'b1, 6'd0, 1'b1));
        tick();
        chk_bit("add_n2_valid", disp_valid, 1'b1);
        chk_ent("add_n2_entry", disp_entry, mk(32'h104, 6'd0, 1'b1, 6'd0, 1'b1));
        tick();
        chk_bit("add_empty", disp_valid, 1'b0);

        // Slot of another station type is ignored
        issue2(mk(32'h1F0, 6'd0, 1'b1, 6'd0, 1'b1), mk(32'h200, 6'd0, 1'b1, 6'd0, 1'b1));
        issue_st_type[0] = 2'd1;
        tick();
        clear_inputs();
        chk_ent("type_filter_entry", disp_entry, mk(32'h200, 6'd0, 1'b1, 6'd0, 1'b1));
        tick();
        chk_bit("type_filter_empty", disp_valid, 1'b0);

        // Wakeup of src1 through CDB port 0
        issue1(mk(32'h300, 6'd5, 1'b0, 6'd0, 1'b1));
        tick();
        clear_inputs();
        chk_bit("wake0_wait1", disp_valid, 1'b0);
        tick();
        chk_bit("wake0_wait2", disp_valid, 1'b0);
        cdb(0, 6'd5, 32'hDEADBEEF);
        tick();
        clear_inputs();
        exp            = mk(32'h300, 6'd5, 1'b0, 6'd0, 1'b1);
        exp.src1.value = 32'hDEADBEEF;
        exp.src1.rdy   = 1'b1;
        chk_ent("wake0_entry", disp_entry, exp);
        tick();
        chk_bit("wake0_gone", disp_valid, 1'b0);

        // Wakeup of src2 through CDB port 1
        issue1(mk(32'h310, 6'd0, 1'b1, 6'd7, 1'b0));
        tick();
        clear_inputs();
        chk_bit("wake1_wait", disp_valid, 1'b0);
        cdb(1, 6'd7, 32'h12345678);
        tick();
        clear_inputs();
        exp            = mk(32'h310, 6'd0, 1'b1, 6'd7, 1'b0);
        exp.src2.value = 32'h12345678;
        exp.src2.rdy   = 1'b1;
        chk_ent("wake1_entry", disp_entry, exp);
        tick();
        chk_bit("wake1_gone", disp_valid, 1'b0);

        // Same-cycle CDB bypass into the issued entry
        issue1(mk(32'h320, 6'd9, 1'b0, 6'd0, 1'b1));
        cdb(0, 6'd9, 32'hCAFEF00D);
        tick();
        clear_inputs();
        exp            = mk(32'h320, 6'd9, 1'b0, 6'd0, 1'b1);
        exp.src1.value = 32'hCAFEF00D;
        exp.src1.rdy   = 1'b1;
        chk_ent("bypass_entry", disp_entry, exp);
        tick();
        chk_bit("bypass_gone", disp_valid, 1'b0);

        // Younger ready entry offered until the older one wakes
        disp_ready = 1'b0;
        ea = mk(32'h330, 6'd3, 1'b0, 6'd0, 1'b1);
        eb = mk(32'h334, 6'd0, 1'b1, 6'd0, 1'b1);
        issue2(ea, eb);
        tick();
        clear_inputs();
        chk_ent("order_young_first", disp_entry, eb);
        cdb(0, 6'd3, 32'h33);
        tick();
        clear_inputs();
        exp            = ea;
        exp.src1.value = 32'h33;
        exp.src1.rdy   = 1'b1;
        chk_ent("order_old_reselect", disp_entry, exp);
        disp_ready = 1'b1;
        tick();
        chk_ent("order_young_after", disp_entry, eb);
        tick();
        chk_bit("order_empty", disp_valid, 1'b0);

        // Fill to capacity with waiting entries
        disp_ready = 1'b0;
        issue2(fk(0), fk(1));
        tick();
        chk_bit("fill2_full", full, 1'b0);
        issue2(fk(2), fk(3));
        tick();
        chk_bit("fill4_full", full, 1'b0);
        issue2(fk(4), fk(5));
        tick();
        chk_bit("fill6_full", full, 1'b0);
        issue1(fk(6));
        tick();
        chk_bit("fill7_full", full, 1'b1);
        chk_bit("fill7_disp_valid", disp_valid, 1'b0);
        chk_bit("fill7_overflow", overflow_err, 1'b0);
        issue2(fk(7), fk(8));
        tick();
        clear_inputs();
        chk_bit("fill8_full", full, 1'b1);
        chk_bit("fill8_overflow", overflow_err, EXP_OVF);

        cdb(0, 6'd21, 32'h2121);
        tick();
        clear_inputs();
        chk_addr("fill_k0_offer", 32'h400);
        disp_ready = 1'b1;
        tick();
        disp_ready = 1'b0;
        chk_bit("cnt7_full", full, 1'b1);
        chk_bit("cnt7_disp_valid", disp_valid, 1'b0);
        cdb(1, 6'd22, 32'h2222);
        tick();
        clear_inputs();
        chk_addr("fill_k1_offer", 32'h404);

        // Dispatch and a 2-wide issue in the same cycle at count 7
        disp_ready = 1'b1;
        issue2(fk(9), fk(10));
        tick();
        clear_inputs();
        disp_ready = 1'b0;
        chk_bit("disp_issue_full", full, 1'b1);
        chk_bit("disp_issue_valid", disp_valid, 1'b0);
        chk_bit("disp_issue_overflow", overflow_err, EXP_OVF);

        // Drain: the dropped k8 (0x420) must be absent, k9/k10 present
        drain_addr = '{32'h408, 32'h40C, 32'h410, 32'h414, 32'h418, 32'h41C, 32'h424, 32'h428};
        cdb(0, 6'd20, 32'h2020);
        tick();
        clear_inputs();
        disp_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            chk_bit("drain_valid", disp_valid, 1'b1);
            chk_addr("drain_addr", drain_addr[j]);
            tick();
        end
        chk_bit("drain_empty", disp_valid, 1'b0);
        chk_bit("drain_full", full, 1'b0);

        // Flush with 5 waiting entries and a concurrent issue
        disp_ready = 1'b0;
        issue2(mk(32'h480, 6'd30, 1'b0, 6'd0, 1'b1), mk(32'h484, 6'd30, 1'b0, 6'd0, 1'b1));
        tick();
        issue2(mk(32'h488, 6'd30, 1'b0, 6'd0, 1'b1), mk(32'h48C, 6'd30, 1'b0, 6'd0, 1'b1));
        tick();
        issue1(mk(32'h490, 6'd30, 1'b0, 6'd0, 1'b1));
        tick();
        issue2(mk(32'h4F0, 6'd0, 1'b1, 6'd0, 1'b1), mk(32'h4F4, 6'd0, 1'b1, 6'd0, 1'b1));
        flush = 1'b1;
        tick();
        clear_inputs();
        chk_bit("flush_disp_valid", disp_valid, 1'b0);
        chk_bit("flush_full", full, 1'b0);
        chk_bit("flush_overflow", overflow_err, EXP_OVF);
        cdb(0, 6'd30, 32'h3030);
        tick();
        clear_inputs();
        chk_bit("flush_stale_wake", disp_valid, 1'b0);
        disp_ready = 1'b1;
        issue2(mk(32'h500, 6'd0, 1'b1, 6'd0, 1'b1), mk(32'h504, 6'd0, 1'b1, 6'd0, 1'b1));
        tick();
        clear_inputs();
        chk_ent("post_flush_first", disp_entry, mk(32'h500, 6'd0, 1'b1, 6'd0, 1'b1));
        tick();
        chk_ent("post_flush_second", disp_entry, mk(32'h504, 6'd0, 1'b1, 6'd0, 1'b1));
        tick();
        chk_bit("post_flush_empty", disp_valid, 1'b0);

        // Reset clears the sticky error
        gsi.reset = 1'b1;
        tick();
        gsi.reset = 1'b0;
        chk_bit("final_overflow", overflow_err, 1'b0);
        chk_bit("final_full", full, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
